// File: rtl/serial_adder_controller_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the width helper for the bit counter.
package serial_adder_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 64;

  // A 1-bit operand still needs a 1-bit counter, so clamp $clog2 at one.
  function automatic int count_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_controller_fa.sv
// 1-bit full adder cell used as the shared datapath of the serial adder,
// built from two half-adder stages.
module full_adder_modular (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  logic half_sum;
  logic half_carry;
  logic second_carry;

  assign half_sum     = a ^ b;
  assign half_carry   = a & b;
  assign sum          = half_sum ^ carry_in;
  assign second_carry = half_sum & carry_in;
  assign carry_out    = half_carry | second_carry;

endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial WIDTH-bit adder: accepts operands by valid/ready, adds one
// bit per clock LSB first through a single full adder, holds the result.
module serial_adder_controller
  import serial_adder_controller_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int             CW   = count_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             c;
  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH:0]   sum_cat;
  logic             last_bit;

  full_adder_modular u_fa (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .carry_in  (c),
    .sum       (fa_sum),
    .carry_out (fa_carry)
  );

  // New sum bit enters at the MSB; the concatenation also covers WIDTH=1.
  assign sum_cat  = {fa_sum, sum_sh};
  assign last_bit = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_next = S_RUN;
      S_RUN:   if (last_bit) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE:  in_ready  = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      c      <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= carry_in;
            count <= '0;
          end
        end
        S_RUN: begin
          c      <= fa_carry;
          sum_sh <= sum_cat[WIDTH:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (!last_bit) begin
            count <= count + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result lines read zero whenever no completed result is being offered.
  assign sum       = out_valid ? sum_sh : '0;
  assign carry_out = out_valid & c;

endmodule

// File: tb/tb_serial_adder_controller.sv
// Self-checking bench for serial_adder_controller (WIDTH=8) using a
// queue of expected results pushed at accept and popped at completion.
module tb_serial_adder_controller;

  localparam int WIDTH = 8;
  localparam int LIMIT = 40;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

  logic [WIDTH:0] exp_q[$];
  int tests_run;
  int tests_failed;

  serial_adder_controller #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands and let the next rising edge accept them.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv);
    logic [WIDTH:0] total;
    @(negedge clk);
    a        = av;
    b        = bv;
    carry_in = cv;
    in_valid = 1'b1;
    total    = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
    exp_q.push_back(total);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded by LIMIT.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sum !== '0 || carry_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, required 1 0 0 00 0",
               in_ready, out_valid, busy, sum, carry_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add(input string name, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic cv);
    int lat;
    logic [WIDTH:0] expv;
    start_op(av, bv, cv);
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_busy: busy=%b in_ready=%b, required 1 0", name, busy, in_ready);
    end
    wait_done(lat);
    tests_run++;
    if (lat !== WIDTH) begin
      tests_failed++;
      $display("[TB] FAIL %s_latency: %0d cycles, required %0d", name, lat, WIDTH);
    end
    expv = exp_q.pop_front();
    if (out_valid) begin
      tests_run++;
      if (sum !== expv[WIDTH-1:0] || carry_out !== expv[WIDTH]) begin
        tests_failed++;
        $display("[TB] FAIL %s_result: sum=%h cout=%b, required sum=%h cout=%b",
                 name, sum, carry_out, expv[WIDTH-1:0], expv[WIDTH]);
      end
    end
    release_result();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s_release: out_valid=%b in_ready=%b, required 0 1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    logic [WIDTH:0] expv;
    start_op(8'h3C, 8'h0F, 1'b0);
    // Competing operands offered while busy must not be taken.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a        = 8'hFF;
      b        = 8'hFF;
      carry_in = 1'b1;
      in_valid = 1'b1;
      tests_run++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL busy_input_%0d: in_ready=%b busy=%b, required 0 1", i, in_ready, busy);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    expv = exp_q.pop_front();
    tests_run++;
    if (!out_valid) begin
      tests_failed++;
      $display("[TB] FAIL bp_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (out_valid !== 1'b1 || sum !== expv[WIDTH-1:0] || carry_out !== expv[WIDTH]) begin
          tests_failed++;
          $display("[TB] FAIL bp_hold_%0d: out_valid=%b sum=%h cout=%b, required 1 %h %b",
                   i, out_valid, sum, carry_out, expv[WIDTH-1:0], expv[WIDTH]);
        end
        @(posedge clk);
        #1;
      end
    end
    release_result();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH:0] discard;
    start_op(8'hFF, 8'h01, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    discard = exp_q.pop_front();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        sum !== '0 || carry_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_run: out_valid=%b in_ready=%b busy=%b sum=%h cout=%b (dropped %h), required 0 1 0 00 0",
               out_valid, in_ready, busy, sum, carry_out, discard);
    end
    @(negedge clk);
    rst = 1'b0;
    test_add("after_reset", 8'h01, 8'h01, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    a            = '0;
    b            = '0;
    carry_in     = 1'b0;
    test_reset();
    test_add("zero", 8'h00, 8'h00, 1'b0);
    test_add("mixed", 8'h3C, 8'h0F, 1'b0);
    test_add("ripple", 8'hFF, 8'h01, 1'b0);
    test_add("cin", 8'hA5, 8'h5A, 1'b1);
    test_back_pressure();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
